ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
Two-master AHB-Lite arbiter feeding the shared system bus: master 0 is the CPU, which is also the default/park master, and master 1 is the DMAC. It consumes the DMAC's Bus_Req and drives its Bus_Grant. It multiplexes address/control from the address-phase owner and write data/strobes from the data-phase owner onto the slave side. A beat counter with a starvation limit prevents long DMA transfers from locking out the CPU indefinitely.

Parameters:
MAX_DMA_BEATS, 16, DMA address-phase beats allowed while cpu_req is pending before the DMA grant is revoked
CNT_W, 5, width of beat counter; must satisfy 2^CNT_W > MAX_DMA_BEATS

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
cpu_req  in  1  CPU requests the bus
cpu_haddr  in  32  CPU address
cpu_htrans  in  2  CPU HTRANS
cpu_hwrite  in  1  CPU HWRITE
cpu_hsize  in  3  CPU HSIZE
cpu_hwdata  in  32  CPU write data
cpu_grant  out  1  CPU owns address phase
Bus_Req  in  1  DMAC bus request
MAddress  in  32  DMAC address
MTrans  in  2  DMAC HTRANS
MWrite  in  1  DMAC HWRITE
MBurst_Size  in  4  DMAC burst size, passed through
MWData  in  32  DMAC write data
MWStrb  in  4  DMAC write strobes
Bus_Grant  out  1  DMAC owns address phase
HREADY  in  1  slave-side ready
HADDR  out  32  muxed address
HTRANS  out  2  muxed HTRANS
HWRITE  out  1  muxed write
HSIZE  out  3  muxed size; DMAC beats drive 3'b010
HBURST_SIZE  out  4  MBurst_Size when DMAC owns, else 0
HWDATA  out  32  muxed data-phase write data
HWSTRB  out  4  MWStrb when DMAC is data owner, else 4'b1111
data_owner  out  1  0 = CPU, 1 = DMAC data phase

Behaviour:
- States: S_CPU, S_DMA, S_RELEASE. Reset (rst=0 at an edge): S_CPU, cpu_grant=1, Bus_Grant=0, data_owner=0, beat counter=0. Mux outputs follow the CPU inputs.
- Grants are registered, decoded from state: cpu_grant=1 in S_CPU only, Bus_Grant=1 in S_DMA only. In S_RELEASE, both are 0, HTRANS is forced to 2'b00, and the remaining address/control outputs hold DMAC values.
- Switch point: HREADY=1 and the current owner's HTRANS is IDLE (00) or NONSEQ (10). No switch ever occurs on SEQ or BUSY.
- S_CPU -> S_DMA: Bus_Req=1 at a switch point. The DMAC has priority over cpu_req. Bus_Grant rises the following cycle. Beat counter clears.
- S_DMA: the beat counter increments on each HREADY=1 cycle with MTrans NONSEQ or SEQ, saturating at MAX_DMA_BEATS.
- S_DMA -> S_RELEASE: Bus_Req=0, or (cpu_req=1 and counter==MAX_DMA_BEATS), evaluated at a switch point.
- S_RELEASE -> S_CPU: when HREADY=1, i.e. the DMAC's last data phase has completed. If Bus_Req is still 1 and cpu_req=0, go to S_DMA instead.
- Data-phase owner: data_owner <= address owner whenever HREADY=1; it holds when HREADY=0. In S_RELEASE the address owner is taken as 1. HWDATA/HWSTRB select on data_owner, so write data follows one cycle behind address.
- Wait states: with HREADY=0, state, counter and data_owner all hold.
- Simultaneous Bus_Req rise and cpu_req: the DMAC wins. If cpu_req is pending at revocation, the CPU gets the bus for at least one switch point before the DMAC can be re-granted.
- Reset mid-transfer: the synchronous reset overrides everything. The next cycle is S_CPU with HTRANS = cpu_htrans. No DMAC beat is completed by the arbiter.

Test Plan:
- Reset: hold rst=0 for 3 edges while Bus_Req=1 -> cpu_grant=1, Bus_Grant=0, data_owner=0, HADDR=cpu_haddr.
- Grant: CPU idle, Bus_Req=1 at edge N -> Bus_Grant=1 from N+1. HADDR=MAddress=32'h0000_1000 and HWRITE=MWrite. HWDATA=MWData one HREADY cycle after the first DMAC NONSEQ.
- Burst protection: DMAC 4-beat SEQ burst with Bus_Req dropped on beat 2 -> Bus_Grant stays 1 until MTrans=IDLE. One S_RELEASE cycle drives HTRANS=00, then cpu_grant=1.
- Starvation: MAX_DMA_BEATS=16, continuous DMA, cpu_req=1 -> revoke at the first switch point after 16 counted beats. CPU gets one grant, then the DMAC is re-granted.
- Wait states: HREADY=0 for 3 cycles during a DMA write -> HWDATA/HWSTRB and data_owner stable, no state change, counter frozen.
- Reset mid-burst: rst=0 during DMAC SEQ beat 3 -> the next cycle has cpu_grant=1, Bus_Grant=0 and HTRANS=cpu_htrans.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
//
// Two-master AHB-Lite arbiter for the shared system bus. Master 0 is the CPU
// and is also the park master. Master 1 is the DMAC. The arbiter does three
// things:
//   - It multiplexes address/control from the address-phase owner.
//   - It multiplexes write data/strobes from the data-phase owner, which lags
//     the address owner by one accepted (HREADY=1) cycle.
//   - It counts DMA beats so that a long DMA transfer cannot starve the CPU.
//
// Ports:
//   clk, rst        system clock; synchronous active-low reset
//   cpu_*           CPU address/control/write-data inputs
//   cpu_req         CPU bus request
//   cpu_grant       CPU owns the address phase
//   Bus_Req         DMAC bus request
//   M*              DMAC address/control/write-data inputs
//   Bus_Grant       DMAC owns the address phase
//   HREADY          slave-side ready
//   H*              multiplexed slave-side address/control/data outputs
//   data_owner      data-phase owner (0 = CPU, 1 = DMAC)
// ---------------------------------------------------------------------------
module ahb_bus_arbiter #(
  parameter int MAX_DMA_BEATS = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [31:0] cpu_haddr,
  input  logic [1:0]  cpu_htrans,
  input  logic        cpu_hwrite,
  input  logic [2:0]  cpu_hsize,
  input  logic [31:0] cpu_hwdata,
  output logic        cpu_grant,
  input  logic        Bus_Req,
  input  logic [31:0] MAddress,
  input  logic [1:0]  MTrans,
  input  logic        MWrite,
  input  logic [3:0]  MBurst_Size,
  input  logic [31:0] MWData,
  input  logic [3:0]  MWStrb,
  output logic        Bus_Grant,
  input  logic        HREADY,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [3:0]  HBURST_SIZE,
  output logic [31:0] HWDATA,
  output logic [3:0]  HWSTRB,
  output logic        data_owner
);

  localparam logic [1:0] S_CPU     = 2'b00;
  localparam logic [1:0] S_DMA     = 2'b01;
  localparam logic [1:0] S_RELEASE = 2'b10;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(MAX_DMA_BEATS);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [1:0]       owner_trans;
  logic             switch_pt;
  logic             dma_beat;
  logic             addr_owner;

  // The handover window (S_RELEASE) still counts as a DMAC address phase.
  // This lets the DMAC's final data phase be tagged to the DMAC.
  assign addr_owner  = (state != S_CPU);
  assign owner_trans = addr_owner ? MTrans : cpu_htrans;

  // Ownership may only change between bursts. That is an accepted cycle
  // whose current transfer is IDLE or the NONSEQ that starts a new burst.
  // A SEQ or BUSY transfer never marks a switch point.
  assign switch_pt = HREADY && (owner_trans == TR_IDLE || owner_trans == TR_NONSEQ);
  assign dma_beat  = HREADY && (MTrans == TR_NONSEQ || MTrans == TR_SEQ);

  // NOTE: every signal assigned in an always_comb gets a default on entry,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_CPU: begin
        // The DMAC has priority over a simultaneous CPU request.
        if (switch_pt && Bus_Req) state_next = S_DMA;
      end
      S_DMA: begin
        if (switch_pt && (!Bus_Req || (cpu_req && beat_cnt == BEAT_LIMIT)))
          state_next = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the DMAC's last data phase to complete. The DMAC may go
        // straight back in only when the CPU is not waiting for the bus.
        if (HREADY) state_next = (Bus_Req && !cpu_req) ? S_DMA : S_CPU;
      end
      default: state_next = S_CPU;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together from values sampled at the same edge, with no
  // order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_CPU;
      beat_cnt   <= '0;
      data_owner <= 1'b0;
    end else if (HREADY) begin
      state      <= state_next;
      data_owner <= addr_owner;
      if (state == S_DMA) begin
        if (dma_beat && beat_cnt != BEAT_LIMIT) beat_cnt <= beat_cnt + 1'b1;
      end else if (state_next == S_DMA) begin
        // Each new DMAC tenure starts its starvation budget from zero.
        beat_cnt <= '0;
      end
    end
  end

  assign cpu_grant = (state == S_CPU);
  assign Bus_Grant = (state == S_DMA);

  // Address/control come from the address owner. During S_RELEASE, HTRANS is
  // forced to IDLE so that no new transfer starts while the bus is handed over.
  assign HADDR       = addr_owner ? MAddress : cpu_haddr;
  assign HTRANS      = (state == S_RELEASE) ? TR_IDLE : owner_trans;
  assign HWRITE      = addr_owner ? MWrite : cpu_hwrite;
  assign HSIZE       = addr_owner ? 3'b010 : cpu_hsize;
  assign HBURST_SIZE = addr_owner ? MBurst_Size : 4'h0;

  // Write data/strobes come from the data owner, one beat behind the address.
  assign HWDATA = data_owner ? MWData : cpu_hwdata;
  assign HWSTRB = data_owner ? MWStrb : 4'b1111;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_bus_arbiter
//
// Randomised scoreboard bench for ahb_bus_arbiter. A stimulus process drives
// random traffic in several phases:
//   - reset
//   - general traffic
//   - a starvation storm
//   - heavy wait states
//   - traffic with random resets
// The stimulus process steps a behavioural ownership model and pushes the
// expected outputs for each cycle into a queue. A monitor process pops one
// entry per cycle, on the falling edge, and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_ahb_bus_arbiter;

  localparam int MAX_BEATS = 16;

  // Ownership of the address phase in the reference model.
  localparam int H_CPU  = 0;
  localparam int H_DMA  = 1;
  localparam int H_HAND = 2;

  localparam int PH_RST   = 0;
  localparam int PH_MIX   = 1;
  localparam int PH_STARV = 2;
  localparam int PH_WAIT  = 3;
  localparam int PH_RRST  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [31:0] cpu_haddr;
  logic [1:0]  cpu_htrans;
  logic        cpu_hwrite;
  logic [2:0]  cpu_hsize;
  logic [31:0] cpu_hwdata;
  logic        cpu_grant;
  logic        Bus_Req;
  logic [31:0] MAddress;
  logic [1:0]  MTrans;
  logic        MWrite;
  logic [3:0]  MBurst_Size;
  logic [31:0] MWData;
  logic [3:0]  MWStrb;
  logic        Bus_Grant;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [3:0]  HBURST_SIZE;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        data_owner;

  typedef struct {
    logic        cpu_grant;
    logic        bus_grant;
    logic        data_owner;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hburst;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_holder = H_CPU;
  int m_beats  = 0;
  int m_data   = 0;

  ahb_bus_arbiter #(.MAX_DMA_BEATS(MAX_BEATS), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_haddr(cpu_haddr), .cpu_htrans(cpu_htrans),
    .cpu_hwrite(cpu_hwrite), .cpu_hsize(cpu_hsize), .cpu_hwdata(cpu_hwdata),
    .cpu_grant(cpu_grant),
    .Bus_Req(Bus_Req), .MAddress(MAddress), .MTrans(MTrans), .MWrite(MWrite),
    .MBurst_Size(MBurst_Size), .MWData(MWData), .MWStrb(MWStrb),
    .Bus_Grant(Bus_Grant),
    .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST_SIZE(HBURST_SIZE), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
    .data_owner(data_owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Advance the model by one clock edge, using the inputs that were stable
  // during the cycle that just ended.
  task automatic model_step();
    int  trans;
    bool_sw: begin end
    if (!rst) begin
      m_holder = H_CPU;
      m_beats  = 0;
      m_data   = 0;
    end else if (HREADY) begin
      trans = (m_holder == H_CPU) ? int'(cpu_htrans) : int'(MTrans);
      // Beats from the cycle that just ended count after the revocation
      // decision, which sees only the beats completed before it.
      case (m_holder)
        H_CPU: begin
          m_data = 0;
          if ((trans == 0 || trans == 2) && Bus_Req) begin
            m_holder = H_DMA;
            m_beats  = 0;
          end
        end
        H_DMA: begin
          m_data = 1;
          if ((trans == 0 || trans == 2) &&
              (!Bus_Req || (cpu_req && m_beats >= MAX_BEATS)))
            m_holder = H_HAND;
          if (MTrans[1]) m_beats++;
        end
        default: begin
          m_data = 1;
          if (Bus_Req && !cpu_req) begin
            m_holder = H_DMA;
            m_beats  = 0;
          end else begin
            m_holder = H_CPU;
          end
        end
      endcase
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    bit   dma_side;
    dma_side     = (m_holder != H_CPU);
    e.cpu_grant  = (m_holder == H_CPU);
    e.bus_grant  = (m_holder == H_DMA);
    e.data_owner = (m_data != 0);
    e.haddr      = dma_side ? MAddress : cpu_haddr;
    e.htrans     = (m_holder == H_HAND) ? 2'b00 : (dma_side ? MTrans : cpu_htrans);
    e.hwrite     = dma_side ? MWrite : cpu_hwrite;
    e.hsize      = dma_side ? 3'b010 : cpu_hsize;
    e.hburst     = dma_side ? MBurst_Size : 4'h0;
    e.hwdata     = (m_data != 0) ? MWData : cpu_hwdata;
    e.hwstrb     = (m_data != 0) ? MWStrb : 4'hF;
    return e;
  endfunction

  task automatic drive(input int phase);
    rst        = !(phase == PH_RST || (phase == PH_RRST && $urandom_range(0, 29) == 0));
    cpu_haddr  = $urandom;
    cpu_htrans = 2'($urandom_range(0, 3));
    cpu_hwrite = 1'($urandom_range(0, 1));
    cpu_hsize  = 3'($urandom_range(0, 2));
    cpu_hwdata = $urandom;
    MAddress   = $urandom;
    MWrite     = 1'($urandom_range(0, 1));
    MBurst_Size = 4'($urandom_range(0, 15));
    MWData     = $urandom;
    MWStrb     = 4'($urandom_range(0, 15));
    case (phase)
      PH_RST: begin
        Bus_Req = 1'b1;
        cpu_req = 1'b0;
        MTrans  = 2'b10;
        HREADY  = 1'b1;
      end
      PH_STARV: begin
        Bus_Req = 1'b1;
        cpu_req = 1'b1;
        MTrans  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
        HREADY  = ($urandom_range(0, 4) != 0);
      end
      PH_WAIT: begin
        if ($urandom_range(0, 11) == 0) Bus_Req = ~Bus_Req;
        cpu_req = 1'($urandom_range(0, 1));
        MTrans  = 2'($urandom_range(0, 3));
        HREADY  = 1'($urandom_range(0, 1));
      end
      default: begin
        if ($urandom_range(0, 7) == 0) Bus_Req = ~Bus_Req;
        cpu_req = 1'($urandom_range(0, 1));
        MTrans  = 2'($urandom_range(0, 3));
        HREADY  = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  // Stimulus plus model: each cycle, step the model at the edge and then
  // apply new inputs. Finally, queue what the DUT must show for the rest of
  // the cycle.
  task automatic run_phase(input int phase, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_step();
      #1;
      drive(phase);
      exp_q.push_back(expected());
    end
  endtask

  initial begin : stimulus
    Bus_Req = 1'b0;
    drive(PH_RST);
    run_phase(PH_RST, 3);
    run_phase(PH_MIX, 400);
    run_phase(PH_STARV, 200);
    run_phase(PH_WAIT, 150);
    run_phase(PH_RRST, 250);
    run_phase(PH_MIX, 100);
    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cpu_grant",   32'(cpu_grant),   32'(e.cpu_grant));
        check("Bus_Grant",   32'(Bus_Grant),   32'(e.bus_grant));
        check("data_owner",  32'(data_owner),  32'(e.data_owner));
        check("HADDR",       HADDR,            e.haddr);
        check("HTRANS",      32'(HTRANS),      32'(e.htrans));
        check("HWRITE",      32'(HWRITE),      32'(e.hwrite));
        check("HSIZE",       32'(HSIZE),       32'(e.hsize));
        check("HBURST_SIZE", 32'(HBURST_SIZE), 32'(e.hburst));
        check("HWDATA",      HWDATA,           e.hwdata);
        check("HWSTRB",      32'(HWSTRB),      32'(e.hwstrb));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
